// File: rtl/serial_byte_tx.sv
// serial_byte_tx: serial transmitter for frames of the form start(0), DATA_W data bits
// sent LSB first, optional parity bit, then STOP_BITS stop bits(1). The line idles at 1.
// Each line bit is held for CLKS_PER_BIT clocks. A 1-entry holding register decouples
// the byte producer from the shifter, so frames go out back-to-back when a byte is waiting.
//
// Optional feature: define SERIAL_TX_PARITY_EN to add a parity bit after the data bits.
// The parity bit is the XOR of the data bits, inverted when PARITY_ODD=1.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   in_valid  in_byte is valid
//   in_byte   byte to send, captured on the in_valid & in_ready edge
//   in_ready  holding register is empty
//   out       serial line (registered, idles at 1)
//   busy      high from the first start-bit cycle through the last stop-bit cycle
//   done      one-cycle pulse in the final clock of the final stop bit
module serial_byte_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_byte,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    // Reject parameter values the frame logic cannot represent.
    if (DATA_W < 1 || CLKS_PER_BIT < 1 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1)
    begin : g_param_check
        $error("serial_byte_tx: illegal parameter value");
    end

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_clk;
    logic              load;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            out_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state, holding register and registered-output logic.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;
        out_d        = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        last_clk  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        clk_cnt_d = (state_q == S_IDLE || last_clk) ? '0 : clk_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (last_clk) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (last_clk) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            S_STOP: begin
                if (last_clk) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Move the held byte into the shifter; this frees the holding register.
        if (load) begin
            state_d      = S_START;
            shift_d      = hold_q;
            bit_cnt_d    = '0;
            hold_valid_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_d     = (^hold_q) ^ 1'(PARITY_ODD);
`endif
        end

        // Accept only when empty; a load and an accept never fall on the same edge.
        if (in_valid && !hold_valid_q) begin
            hold_d       = in_byte;
            hold_valid_d = 1'b1;
        end

        // Outputs follow the next state so they line up with it on the same edge.
        case (state_d)
            S_IDLE:   out_d = 1'b1;
            S_START:  out_d = 1'b0;
            S_DATA:   out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: out_d = parity_d;
`endif
            S_STOP: begin
                out_d  = 1'b1;
                done_d = (bit_cnt_d == BIT_W'(STOP_BITS - 1)) &&
                         (clk_cnt_d == CNT_W'(CLKS_PER_BIT - 1));
            end
            default:  out_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign in_ready = !hold_valid_q;
    assign out      = out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
`timescale 1ns/1ps
module tb_serial_byte_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME0 = 8 + 1 + PAR_BITS + 1;
    localparam int DUR1   = (8 + 1 + PAR_BITS + 2) * 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid0, in_valid1;
    logic [7:0] in_byte0, in_byte1;
    logic       in_ready0, out0, busy0, done0;
    logic       in_ready1, out1, busy1, done1;

    always #5 clk = ~clk;

    serial_byte_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_byte(in_byte0),
        .in_ready(in_ready0), .out(out0), .busy(busy0), .done(done0)
    );

    serial_byte_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_byte(in_byte1),
        .in_ready(in_ready1), .out(out1), .busy(busy1), .done(done1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of per-cycle {out, busy, done} for frames in flight,
    // plus a one-entry holding register.
    typedef logic [2:0] cyc_t;
    typedef cyc_t cyc_q_t[$];

    cyc_q_t     mq0, mq1;
    logic       mhv0 = 1'b0, mhv1 = 1'b0;
    logic [7:0] mhb0 = 8'h00, mhb1 = 8'h00;

    function automatic void build_frame(input logic [7:0] b, input int cpb, input int stops,
                                        inout cyc_q_t q);
        int nbits;
        logic v;
        nbits = 1 + 8 + PAR_BITS + stops;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)                        v = 1'b0;
            else if (i <= 8)                   v = b[i-1];
            else if (PAR_BITS == 1 && i == 9)  v = ^b;
            else                               v = 1'b1;
            for (int c = 0; c < cpb; c++)
                q.push_back({v, 1'b1, (i == nbits - 1) && (c == cpb - 1)});
        end
    endfunction

    task automatic model_edge(inout cyc_q_t q, inout logic hv, inout logic [7:0] hb,
                              input logic acc, input logic [7:0] din,
                              input int cpb, input int stops);
        if (q.size() > 0) void'(q.pop_front());
        if (q.size() == 0 && hv) begin
            build_frame(hb, cpb, stops, q);
            hv = 1'b0;
        end
        if (acc) begin
            hb = din;
            hv = 1'b1;
        end
    endtask

    function automatic cyc_t head(input cyc_q_t q);
        return (q.size() > 0) ? q[0] : 3'b100;
    endfunction

    // One clock: model follows the edge, DUT outputs compared at the falling edge.
    task automatic cycle();
        logic acc0, acc1;
        cyc_t e0, e1;
        acc0 = in_valid0 && !mhv0;
        acc1 = in_valid1 && !mhv1;
        @(posedge clk);
        model_edge(mq0, mhv0, mhb0, acc0, in_byte0, 1, 1);
        model_edge(mq1, mhv1, mhb1, acc1, in_byte1, 4, 2);
        @(negedge clk);
        e0 = head(mq0);
        e1 = head(mq1);
        check_bit("m0_out",  out0,  e0[2]);
        check_bit("m0_busy", busy0, e0[1]);
        check_bit("m0_done", done0, e0[0]);
        check_bit("m0_rdy",  in_ready0, !mhv0);
        check_bit("m1_out",  out1,  e1[2]);
        check_bit("m1_busy", busy1, e1[1]);
        check_bit("m1_done", done1, e1[0]);
        check_bit("m1_rdy",  in_ready1, !mhv1);
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        mhv0 = 1'b0;
        mhv1 = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] line;   // bit k is the line value in frame cycle k
    } vec_t;

    vec_t vecs [6];
    logic rec_out [0:63];
    logic rec_busy[0:63];
    logic rec_done[0:63];
    int   busy_cnt, done_cnt, done_at;

    initial begin
`ifdef SERIAL_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
        vecs[1] = '{8'h3C, 11'b1_0_00111100_0};
        vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
        vecs[3] = '{8'h00, 11'b1_0_00000000_0};
        vecs[4] = '{8'h01, 11'b1_1_00000001_0};
        vecs[5] = '{8'h80, 11'b1_1_10000000_0};
`else
        vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
        vecs[1] = '{8'h3C, 11'b0_1_00111100_0};
        vecs[2] = '{8'hFF, 11'b0_1_11111111_0};
        vecs[3] = '{8'h00, 11'b0_1_00000000_0};
        vecs[4] = '{8'h01, 11'b0_1_00000001_0};
        vecs[5] = '{8'h80, 11'b0_1_10000000_0};
`endif
        reset     = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_byte0  = 8'h00;
        in_byte1  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_bit("rst_out",  out0, 1'b1);
        check_bit("rst_rdy",  in_ready0, 1'b1);
        check_bit("rst_busy", busy0, 1'b0);
        check_bit("rst_done", done0, 1'b0);
        reset = 1'b0;

        // Idle line after reset.
        for (int c = 0; c < 20; c++) begin
            cycle();
            check_bit("idle_out",  out0, 1'b1);
            check_bit("idle_busy", busy0, 1'b0);
            check_bit("idle_done", done0, 1'b0);
            check_bit("idle_rdy",  in_ready0, 1'b1);
        end

        // Single frames against hand-written line patterns.
        for (int v = 0; v < 6; v++) begin
            in_valid0 = 1'b1;
            in_byte0  = vecs[v].data;
            cycle();
            in_valid0 = 1'b0;
            in_byte0  = 8'($urandom);
            cycle();
            for (int k = 0; k < FRAME0; k++) begin
                check_bit("tbl_out",  out0, vecs[v].line[k]);
                check_bit("tbl_busy", busy0, 1'b1);
                check_bit("tbl_done", done0, k == FRAME0 - 1);
                cycle();
            end
            check_bit("tbl_end_out",  out0, 1'b1);
            check_bit("tbl_end_busy", busy0, 1'b0);
            check_bit("tbl_end_done", done0, 1'b0);
        end

        // Back-to-back frames: 0x3C, then 0xFF offered from the next cycle.
        in_valid0 = 1'b1;
        in_byte0  = 8'h3C;
        cycle();
        in_byte0  = 8'hFF;
        for (int c = 0; c < 2 * FRAME0 + 1; c++) begin
            logic acc;
            acc = in_valid0 && !mhv0;
            cycle();
            if (acc) begin
                in_valid0 = 1'b0;
                in_byte0  = 8'h00;
            end
            rec_out[c]  = out0;
            rec_busy[c] = busy0;
            rec_done[c] = done0;
        end
        for (int c = 0; c < 2 * FRAME0; c++) begin
            check_bit("b2b_out", rec_out[c],
                      (c < FRAME0) ? vecs[1].line[c] : vecs[2].line[c - FRAME0]);
            check_bit("b2b_busy", rec_busy[c], 1'b1);
            check_bit("b2b_done", rec_done[c], (c == FRAME0 - 1) || (c == 2 * FRAME0 - 1));
        end
        check_bit("b2b_end_out",  rec_out[2 * FRAME0], 1'b1);
        check_bit("b2b_end_busy", rec_busy[2 * FRAME0], 1'b0);

        // Four clocks per bit, two stop bits: 0x01.
        in_valid1 = 1'b1;
        in_byte1  = 8'h01;
        cycle();
        in_valid1 = 1'b0;
        in_byte1  = 8'($urandom);
        busy_cnt  = 0;
        done_cnt  = 0;
        done_at   = -1;
        for (int c = 0; c < DUR1 + 8; c++) begin
            logic e;
            cycle();
            if (c < 4)       e = 1'b0;
            else if (c < 8)  e = 1'b1;
            else if (c < 36) e = 1'b0;
            else             e = 1'b1;
            check_bit("cpb4_out",  out1, e);
            check_bit("cpb4_busy", busy1, c < DUR1);
            if (busy1) busy_cnt++;
            if (done1) begin
                done_cnt++;
                done_at = c;
            end
        end
        check_int("cpb4_busy_cycles", busy_cnt, DUR1);
        check_int("cpb4_done_count",  done_cnt, 1);
        check_int("cpb4_done_at",     done_at, DUR1 - 1);

        // Reset during data bit 3 of 0x00 while 0x55 waits in the holding register.
        in_valid0 = 1'b1;
        in_byte0  = 8'h00;
        cycle();
        in_byte0  = 8'h55;
        cycle();
        cycle();
        in_valid0 = 1'b0;
        in_byte0  = 8'h00;
        cycle();
        cycle();
        cycle();
        check_bit("abort_pre_rdy", in_ready0, 1'b0);
        check_bit("abort_pre_out", out0, 1'b0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_bit("abort_out",  out0, 1'b1);
        check_bit("abort_rdy",  in_ready0, 1'b1);
        check_bit("abort_busy", busy0, 1'b0);
        check_bit("abort_done", done0, 1'b0);
        cycle();
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (done0) done_cnt++;
        end
        check_int("abort_no_done", done_cnt, 0);
        in_valid0 = 1'b1;
        in_byte0  = 8'hC3;
        cycle();
        in_valid0 = 1'b0;
        for (int c = 0; c < FRAME0 + 4; c++) cycle();

        // Randomized traffic on both instances, checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic a0, a1;
            a0 = in_valid0 && !mhv0;
            a1 = in_valid1 && !mhv1;
            cycle();
            if (a0) in_valid0 = 1'b0;
            if (a1) in_valid1 = 1'b0;
            if (!in_valid0) begin
                in_byte0 = 8'($urandom);
                if ($urandom_range(0, 3) == 0) in_valid0 = 1'b1;
            end
            if (!in_valid1) begin
                in_byte1 = 8'($urandom);
                if ($urandom_range(0, 15) == 0) in_valid1 = 1'b1;
            end
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        for (int c = 0; c < 120; c++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
